// File: rtl/wm_pkg.sv
// wm_pkg: shared phase codes, sequencer states and program record for the washing-machine sequencer.
package wm_pkg;
  localparam int WM_W = 5;
  localparam logic [1:0] PH_IDLE = 2'd0, PH_WASH = 2'd1, PH_RINSE = 2'd2, PH_SPIN = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_WASH, S_RINSE, S_SPIN, S_DONE} state_t;
  typedef struct packed {
    logic [WM_W-1:0] wash;
    logic [WM_W-1:0] rinse;
    logic [WM_W-1:0] spin;
    logic [WM_W-1:0] cloth;
  } prog_t;
endpackage

// File: rtl/wm_program_store.sv
// wm_program_store: DEPTH-slot program register file with a registered read port and a live port for start snapshots.
module wm_program_store #(
  parameter int W = 5,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic [AW-1:0]   addr,
  input  logic [4*W-1:0]  wdata,
  output logic [4*W-1:0]  rdata,
  output logic [4*W-1:0]  cur,
  output logic            rd_valid
);
  logic [4*W-1:0] mem [DEPTH];
  assign cur = mem[addr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en) mem[addr] <= wdata;
      rdata <= rd_en ? mem[addr] : '0;
      rd_valid <= rd_en;
    end
endmodule

// File: rtl/wm_program_sequencer.sv
// wm_program_sequencer: program store plus a WASH/RINSE/SPIN countdown sequencer with prescaled time units.
module wm_program_sequencer
  import wm_pkg::*;
#(
  parameter int W = 5,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH),
  parameter int TICK_DIV = 1,
  parameter int MAX_LOAD = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wash_in,
  input  logic [W-1:0]  rinse_in,
  input  logic [W-1:0]  spin_in,
  input  logic [W-1:0]  cloth_in,
  output logic [W-1:0]  wash_out,
  output logic [W-1:0]  rinse_out,
  output logic [W-1:0]  spin_out,
  output logic [W-1:0]  cloth_out,
  output logic          rd_valid,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic [1:0]    phase,
  output logic [W-1:0]  time_left,
  output logic          done,
  output logic          err
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  state_t state, state_n;
  logic [W-1:0] tl, tl_n, snap_r, snap_r_n, snap_s, snap_s_n;
  logic [W-1:0] c_wash, c_rinse, c_spin, c_cloth;
  logic [PW-1:0] pre, pre_n;
  logic [4*W-1:0] cur, rdata;
  logic err_n, wrap;
  wm_program_store #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_store (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata({wash_in, rinse_in, spin_in, cloth_in}),
    .rdata(rdata), .cur(cur), .rd_valid(rd_valid)
  );
  assign {wash_out, rinse_out, spin_out, cloth_out} = rdata;
  assign {c_wash, c_rinse, c_spin, c_cloth} = cur;
  assign wrap = pre == PW'(TICK_DIV - 1);
  // Only rinse and spin need snapshots: wash is loaded straight into tl at start.
  always_comb begin
    state_n = state;
    tl_n = tl;
    pre_n = pre;
    snap_r_n = snap_r;
    snap_s_n = snap_s;
    err_n = 1'b0;
    case (state)
      S_IDLE: if (start && !abort) begin
        if (c_cloth == '0 || c_cloth > W'(MAX_LOAD)) err_n = 1'b1;
        else begin
          snap_r_n = c_rinse;
          snap_s_n = c_spin;
          pre_n = '0;
          state_n = c_wash != '0 ? S_WASH : c_rinse != '0 ? S_RINSE : c_spin != '0 ? S_SPIN : S_DONE;
          tl_n = c_wash != '0 ? c_wash : c_rinse != '0 ? c_rinse : c_spin;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: if (abort) begin
        state_n = S_IDLE;
        tl_n = '0;
        pre_n = '0;
      end else if (!wrap) pre_n = pre + 1'b1;
      else begin
        pre_n = '0;
        tl_n = tl - 1'b1;
        if (tl == W'(1)) begin
          state_n = (state == S_WASH && snap_r != '0) ? S_RINSE : (state != S_SPIN && snap_s != '0) ? S_SPIN : S_DONE;
          tl_n = (state == S_WASH && snap_r != '0) ? snap_r : (state != S_SPIN) ? snap_s : '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      tl <= '0;
      pre <= '0;
      snap_r <= '0;
      snap_s <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      tl <= tl_n;
      pre <= pre_n;
      snap_r <= snap_r_n;
      snap_s <= snap_s_n;
      err <= err_n;
    end
  assign busy = state == S_WASH || state == S_RINSE || state == S_SPIN;
  assign phase = state == S_WASH ? PH_WASH : state == S_RINSE ? PH_RINSE : state == S_SPIN ? PH_SPIN : PH_IDLE;
  assign done = state == S_DONE;
  assign time_left = tl;
endmodule
